// File: rtl/lru_pkg.sv
// Shared definitions for the load-return unit: load opcode, FSM states, address regions.
package lru_pkg;

  localparam logic [4:0] UOP_LDR = 5'd10;

  typedef enum logic [0:0] {
    IDLE,
    WAIT_DC
  } lru_state_e;

  typedef enum logic [1:0] {
    REG_DC,
    REG_IO,
    REG_NONE
  } lru_region_e;

  // Index width for a bank of n entries; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lru_addr_decode.sv
// Combinational load-address decoder: classifies an address as d-cache, I/O or unmapped.
module lru_addr_decode
  import lru_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DC_WORDS = 31,
  parameter int unsigned N_IO     = 2,
  parameter int unsigned IO_IDX_W = idx_width(N_IO)
) (
  input  logic [ADDR_W-1:0]   addr_i,
  output lru_region_e         region_o,
  output logic [IO_IDX_W-1:0] io_idx_o
);

  // Region bounds are held at full address width so high address bits always participate.
  localparam logic [ADDR_W-1:0] DcEnd = ADDR_W'(DC_WORDS);
  localparam logic [ADDR_W-1:0] IoEnd = ADDR_W'(DC_WORDS + N_IO);

  always_comb begin
    region_o = REG_NONE;
    io_idx_o = IO_IDX_W'(addr_i - DcEnd);
    if (addr_i < DcEnd) begin
      region_o = REG_DC;
    end else if (addr_i < IoEnd) begin
      region_o = REG_IO;
    end
  end

endmodule

// File: rtl/load_return_unit.sv
// Registered write-back selector: forwards ALU results, serves I/O loads directly and runs
// d-cache loads as a stalling request/response transaction with a timeout.
module load_return_unit
  import lru_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DC_WORDS = 31,
  parameter int unsigned N_IO     = 2,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_in,
  input  logic [4:0]             uop,
  input  logic [4:0]             rd_idx,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      alu,
  input  logic [N_IO*DATA_W-1:0] io_rdata,
  output logic                   dc_req,
  output logic [ADDR_W-1:0]      dc_addr,
  input  logic [DATA_W-1:0]      dc_rdata,
  input  logic                   dc_rvalid,
  output logic                   stall,
  output logic                   wb_valid,
  output logic [4:0]             wb_rd,
  output logic [DATA_W-1:0]      wb_data,
  output logic                   bus_err
);

  localparam int unsigned IoIdxW = idx_width(N_IO);
  localparam int unsigned CntW   = $clog2(TIMEOUT + 1);

  lru_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [4:0]        rd_q, rd_d;
  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              bus_err_q, bus_err_d;

  lru_region_e       region;
  logic [IoIdxW-1:0] io_idx;
  logic [DATA_W-1:0] io_word;
  logic              accept;
  logic              is_ldr;

  lru_addr_decode #(
    .ADDR_W   (ADDR_W),
    .DC_WORDS (DC_WORDS),
    .N_IO     (N_IO),
    .IO_IDX_W (IoIdxW)
  ) u_addr_decode (
    .addr_i   (addr),
    .region_o (region),
    .io_idx_o (io_idx)
  );

  always_comb begin
    io_word = '0;
    for (int unsigned i = 0; i < N_IO; i++) begin
      if (io_idx == IoIdxW'(i)) begin
        io_word = io_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign accept  = valid_in && (state_q == IDLE);
  assign is_ldr  = (uop == UOP_LDR);
  assign dc_req  = accept && is_ldr && (region == REG_DC);
  assign dc_addr = dc_req ? addr : '0;
  // Registered state only, so upstream never sees a loop through valid_in.
  assign stall   = (state_q == WAIT_DC);

  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign bus_err  = bus_err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    cnt_inc    = cnt_q + CntW'(1);
    wb_valid_d = 1'b0;
    wb_rd_d    = '0;
    wb_data_d  = '0;
    bus_err_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          if (!is_ldr) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_idx;
            wb_data_d  = alu;
          end else begin
            unique case (region)
              REG_DC: begin
                state_d = WAIT_DC;
                cnt_d   = '0;
                rd_d    = rd_idx;
              end
              REG_IO: begin
                wb_valid_d = 1'b1;
                wb_rd_d    = rd_idx;
                wb_data_d  = io_word;
              end
              default: begin
                wb_valid_d = 1'b1;
                wb_rd_d    = rd_idx;
                bus_err_d  = 1'b1;
              end
            endcase
          end
        end
      end
      WAIT_DC: begin
        // A response arriving in the final wait cycle still beats the timeout.
        if (dc_rvalid) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = dc_rdata;
          state_d    = IDLE;
          cnt_d      = '0;
        end else if (cnt_inc == CntW'(TIMEOUT)) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          bus_err_d  = 1'b1;
          state_d    = IDLE;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      bus_err_q  <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_load_return_unit.sv
// Self-checking bench for load_return_unit: scoreboard of expected write-backs with cycle stamps.
module tb_load_return_unit;
  import lru_pkg::*;

  localparam int unsigned DataW   = 32;
  localparam int unsigned AddrW   = 40;
  localparam int unsigned DcWords = 31;
  localparam int unsigned NIo     = 2;
  localparam int unsigned Timeout = 15;
  localparam logic [4:0]  UopAdd  = 5'd0;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  valid_in;
  logic [4:0]            uop;
  logic [4:0]            rd_idx;
  logic [AddrW-1:0]      addr;
  logic [DataW-1:0]      alu;
  logic [NIo*DataW-1:0]  io_rdata;
  logic                  dc_req;
  logic [AddrW-1:0]      dc_addr;
  logic [DataW-1:0]      dc_rdata;
  logic                  dc_rvalid;
  logic                  stall;
  logic                  wb_valid;
  logic [4:0]            wb_rd;
  logic [DataW-1:0]      wb_data;
  logic                  bus_err;

  typedef struct {
    logic [4:0]       rd;
    logic [DataW-1:0] data;
    logic             err;
    int unsigned      cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int unsigned cyc = 0;
  int unsigned errors = 0;
  int unsigned checks = 0;

  load_return_unit #(
    .DATA_W   (DataW),
    .ADDR_W   (AddrW),
    .DC_WORDS (DcWords),
    .N_IO     (NIo),
    .TIMEOUT  (Timeout)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .uop       (uop),
    .rd_idx    (rd_idx),
    .addr      (addr),
    .alu       (alu),
    .io_rdata  (io_rdata),
    .dc_req    (dc_req),
    .dc_addr   (dc_addr),
    .dc_rdata  (dc_rdata),
    .dc_rvalid (dc_rvalid),
    .stall     (stall),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic drive(input logic v, input logic [4:0] u, input logic [4:0] rd,
                       input logic [AddrW-1:0] a, input logic [DataW-1:0] d);
    valid_in = v;
    uop      = u;
    rd_idx   = rd;
    addr     = a;
    alu      = d;
  endtask

  task automatic push(input logic [4:0] rd, input logic [DataW-1:0] d, input logic err,
                      input int unsigned at);
    exp_t x;
    x.rd = rd; x.data = d; x.err = err; x.cyc = at;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, UopAdd, 5'd0, '0, '0);
    io_rdata = '0; dc_rdata = '0; dc_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b, required 0", wb_valid); end
    checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL reset_wb_rd: got %0d, required 0", wb_rd); end
    checks++; if (wb_data !== '0) begin errors++; $display("FAIL reset_wb_data: got %h, required 0", wb_data); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err: got %b, required 0", bus_err); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b, required 0", stall); end
    checks++; if (dc_req !== 1'b0 || dc_addr !== '0) begin errors++; $display("FAIL reset_dc: got req=%b addr=%h, required 0/0", dc_req, dc_addr); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    drive(1'b1, UopAdd, 5'd3, 40'd5, 32'h1234_5678);
    push(5'd3, 32'h1234_5678, 1'b0, cyc + 1);
    #1;
    checks++; if (dc_req !== 1'b0) begin errors++; $display("FAIL alu_dc_req: got %b, required 0", dc_req); end
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b, required 0", stall); end
      if (wb_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL alu_wb: got extra write-back rd=%0d data=%h cyc=%0d, required none", wb_rd, wb_data, cyc);
        end else begin
          e = sb.pop_front();
          if (wb_rd !== e.rd || wb_data !== e.data || bus_err !== e.err || cyc != e.cyc) begin
            errors++; $display("FAIL alu_wb: got rd=%0d data=%h err=%b cyc=%0d, required rd=%0d data=%h err=%b cyc=%0d", wb_rd, wb_data, bus_err, cyc, e.rd, e.data, e.err, e.cyc);
          end
        end
      end
      drive(1'b0, UopAdd, 5'd0, '0, '0);
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL alu_drain: got %0d pending, required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_io();
    drive(1'b1, UOP_LDR, 5'd4, 40'd31, 32'h0);
    io_rdata = {32'h5A5A_0001, 32'h0000_00A5};
    push(5'd4, 32'h0000_00A5, 1'b0, cyc + 1);
    #1;
    checks++; if (dc_req !== 1'b0) begin errors++; $display("FAIL io_dc_req: got %b, required 0", dc_req); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL io_stall: got %b, required 0", stall); end
      if (wb_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL io_wb: got extra write-back rd=%0d data=%h cyc=%0d, required none", wb_rd, wb_data, cyc);
        end else begin
          e = sb.pop_front();
          if (wb_rd !== e.rd || wb_data !== e.data || bus_err !== e.err || cyc != e.cyc) begin
            errors++; $display("FAIL io_wb: got rd=%0d data=%h err=%b cyc=%0d, required rd=%0d data=%h err=%b cyc=%0d", wb_rd, wb_data, bus_err, cyc, e.rd, e.data, e.err, e.cyc);
          end
        end
      end
      if (i == 1) begin
        // Low word changes so a late sample of the first load would be visible.
        drive(1'b1, UOP_LDR, 5'd5, 40'd32, 32'h0);
        io_rdata = {32'h5A5A_0001, 32'hFFFF_0000};
        push(5'd5, 32'h5A5A_0001, 1'b0, cyc + 1);
      end else begin
        drive(1'b0, UopAdd, 5'd0, '0, '0);
        io_rdata = '0;
      end
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL io_drain: got %0d pending, required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_unmapped();
    logic [AddrW-1:0] addrs [3] = '{40'h1_0000_0021, 40'd40, 40'd33};
    for (int i = 0; i <= 3; i++) begin
      if (i < 3) begin
        drive(1'b1, UOP_LDR, 5'(20 + i), addrs[i], 32'hFFFF_FFFF);
        push(5'(20 + i), 32'h0, 1'b1, cyc + 1);
        #1;
        checks++; if (dc_req !== 1'b0) begin errors++; $display("FAIL unmapped_dc_req: got %b for addr %h, required 0", dc_req, addrs[i]); end
      end else begin
        drive(1'b0, UopAdd, 5'd0, '0, '0);
      end
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL unmapped_stall: got %b, required 0", stall); end
      if (wb_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL unmapped_wb: got extra write-back rd=%0d data=%h cyc=%0d, required none", wb_rd, wb_data, cyc);
        end else begin
          e = sb.pop_front();
          if (wb_rd !== e.rd || wb_data !== e.data || bus_err !== e.err || cyc != e.cyc) begin
            errors++; $display("FAIL unmapped_wb: got rd=%0d data=%h err=%b cyc=%0d, required rd=%0d data=%h err=%b cyc=%0d", wb_rd, wb_data, bus_err, cyc, e.rd, e.data, e.err, e.cyc);
          end
        end
      end
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL unmapped_drain: got %0d pending, required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_dcache();
    int unsigned c;
    c = cyc;
    drive(1'b1, UOP_LDR, 5'd7, 40'd5, 32'h0);
    push(5'd7, 32'hDEAD_BEEF, 1'b0, c + 4);
    push(5'd9, 32'h0000_0077, 1'b0, c + 5);
    #1;
    checks++; if (dc_req !== 1'b1 || dc_addr !== 40'd5) begin errors++; $display("FAIL dc_req: got req=%b addr=%h, required 1/5", dc_req, dc_addr); end
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      checks++; if (stall !== (i <= 3)) begin errors++; $display("FAIL dc_stall: got %b at +%0d, required %b", stall, i, (i <= 3)); end
      if (wb_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL dc_wb: got extra write-back rd=%0d data=%h cyc=%0d, required none", wb_rd, wb_data, cyc);
        end else begin
          e = sb.pop_front();
          if (wb_rd !== e.rd || wb_data !== e.data || bus_err !== e.err || cyc != e.cyc) begin
            errors++; $display("FAIL dc_wb: got rd=%0d data=%h err=%b cyc=%0d, required rd=%0d data=%h err=%b cyc=%0d", wb_rd, wb_data, bus_err, cyc, e.rd, e.data, e.err, e.cyc);
          end
        end
      end
      // Upstream holds the ADD while stalled; it must be taken only once stall drops.
      if (i <= 4) drive(1'b1, UopAdd, 5'd9, 40'd1, 32'h0000_0077);
      else drive(1'b0, UopAdd, 5'd0, '0, '0);
      dc_rvalid = (i == 3) || (i == 5);
      dc_rdata  = (i == 3) ? 32'hDEAD_BEEF : 32'hBAD0_BAD0;
      if (i <= 4) begin
        #1;
        checks++; if (dc_req !== 1'b0) begin errors++; $display("FAIL dc_req_hold: got %b at +%0d, required 0", dc_req, i); end
      end
    end
    dc_rvalid = 1'b0;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL dc_drain: got %0d pending, required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_timeout(input int unsigned rv_at, input logic [AddrW-1:0] a);
    int unsigned c;
    c = cyc;
    drive(1'b1, UOP_LDR, 5'd12, a, 32'h0);
    if (rv_at == Timeout) push(5'd12, 32'hCAFE_F00D, 1'b0, c + Timeout + 1);
    else push(5'd12, 32'h0, 1'b1, c + Timeout + 1);
    #1;
    checks++; if (dc_req !== 1'b1 || dc_addr !== a) begin errors++; $display("FAIL to_dc_req: got req=%b addr=%h, required 1/%h", dc_req, dc_addr, a); end
    for (int i = 1; i <= Timeout + 4; i++) begin
      @(negedge clk);
      checks++; if (stall !== (i <= Timeout)) begin errors++; $display("FAIL to_stall: got %b at +%0d, required %b", stall, i, (i <= Timeout)); end
      if (wb_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL to_wb: got extra write-back rd=%0d data=%h cyc=%0d, required none", wb_rd, wb_data, cyc);
        end else begin
          e = sb.pop_front();
          if (wb_rd !== e.rd || wb_data !== e.data || bus_err !== e.err || cyc != e.cyc) begin
            errors++; $display("FAIL to_wb: got rd=%0d data=%h err=%b cyc=%0d, required rd=%0d data=%h err=%b cyc=%0d", wb_rd, wb_data, bus_err, cyc, e.rd, e.data, e.err, e.cyc);
          end
        end
      end
      drive(1'b0, UopAdd, 5'd0, '0, '0);
      dc_rvalid = (i == rv_at);
      dc_rdata  = 32'hCAFE_F00D;
    end
    dc_rvalid = 1'b0;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL to_drain: got %0d pending, required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]       uops  [5] = '{UopAdd, UOP_LDR, 5'd31, UOP_LDR, 5'd9};
    logic [AddrW-1:0] addrs [5] = '{40'hFF_FFFF_FFFF, 40'd32, 40'd3, 40'd33, 40'd0};
    logic [DataW-1:0] alus  [5] = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
    logic [DataW-1:0] datas [5] = '{32'h1, 32'h6666_0002, 32'h3, 32'h0, 32'h5};
    logic             errs  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    io_rdata = {32'h6666_0002, 32'h6666_0001};
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) begin
        drive(1'b1, uops[i], 5'(i + 1), addrs[i], alus[i]);
        push(5'(i + 1), datas[i], errs[i], cyc + 1);
        #1;
        checks++; if (dc_req !== 1'b0) begin errors++; $display("FAIL b2b_dc_req: got %b at %0d, required 0", dc_req, i); end
      end else begin
        drive(1'b0, UopAdd, 5'd0, '0, '0);
      end
      @(negedge clk);
      checks++; if (wb_valid !== (i < 5)) begin errors++; $display("FAIL b2b_rate: got wb_valid=%b at %0d, required %b", wb_valid, i, (i < 5)); end
      if (wb_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL b2b_wb: got extra write-back rd=%0d data=%h cyc=%0d, required none", wb_rd, wb_data, cyc);
        end else begin
          e = sb.pop_front();
          if (wb_rd !== e.rd || wb_data !== e.data || bus_err !== e.err || cyc != e.cyc) begin
            errors++; $display("FAIL b2b_wb: got rd=%0d data=%h err=%b cyc=%0d, required rd=%0d data=%h err=%b cyc=%0d", wb_rd, wb_data, bus_err, cyc, e.rd, e.data, e.err, e.cyc);
          end
        end
      end
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d pending, required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_reset_mid_wait();
    drive(1'b1, UOP_LDR, 5'd14, 40'd2, 32'h0);
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      drive(1'b0, UopAdd, 5'd0, '0, '0);
    end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rstw_pre_stall: got %b, required 1", stall); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (stall !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL rstw_async: got stall=%b wb_valid=%b, required 0/0", stall, wb_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      dc_rvalid = (i <= 2);
      dc_rdata  = 32'h1357_9BDF;
      @(negedge clk);
      checks++;
      if (wb_valid !== 1'b0 || stall !== 1'b0 || wb_data !== '0 || bus_err !== 1'b0 || wb_rd !== 5'd0) begin
        errors++; $display("FAIL rstw_quiet: got wb_valid=%b stall=%b data=%h err=%b rd=%0d, required all 0", wb_valid, stall, wb_data, bus_err, wb_rd);
      end
    end
    dc_rvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_io();
    test_unmapped();
    test_dcache();
    test_timeout(0, 40'd0);
    test_timeout(Timeout, 40'd30);
    test_back_to_back();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_return_unit.md
# load_return_unit

Registered write-back selector between the execute stage and the register file's write port. It generalises the combinational return mux. Non-load results are forwarded from the ALU. Loads are decoded against a parametrised address map: d-cache words, a bank of memory-mapped I/O registers, or unmapped. D-cache loads become a request/response transaction that stalls the front end until data returns or a timeout fires. Unmapped and timed-out accesses return zero and raise an error flag.

## Interface
- DATA_W, 32, datapath width
- ADDR_W, 32, address width
- DC_WORDS, 31, d-cache words; addresses 0..DC_WORDS-1
- N_IO, 2, I/O registers at addresses DC_WORDS..DC_WORDS+N_IO-1 (first is GPIO state)
- TIMEOUT, 15, max cycles waited for d-cache data; ≥1
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid_in  in  1  instruction presented; accepted only when stall=0
- uop  in  5  micro-op code
- rd_idx  in  5  destination register
- addr  in  ADDR_W  load address (ALU-computed)
- alu  in  DATA_W  ALU result
- io_rdata  in  N_IO*DATA_W  I/O register values, register i at bits [i*DATA_W +: DATA_W]
- dc_req  out  1  d-cache read request, one-cycle pulse
- dc_addr  out  ADDR_W  d-cache address, valid with dc_req
- dc_rdata  in  DATA_W  d-cache read data
- dc_rvalid  in  1  d-cache data valid
- stall  out  1  upstream must hold its instruction
- wb_valid  out  1  register-file write enable
- wb_rd  out  5  write-back register index
- wb_data  out  DATA_W  write-back data
- bus_err  out  1  qualifies wb_valid: load was unmapped or timed out

## Operation
- States: IDLE, WAIT_DC.
- Accept: valid_in=1 and state=IDLE. In WAIT_DC, valid_in is ignored.
- Non-LDR accepted: wb_data=alu, bus_err=0, next cycle.
- LDR, addr < DC_WORDS:
  - dc_req=1 and dc_addr=addr combinationally in the accept cycle.
  - rd_idx is latched; state goes to WAIT_DC.
- LDR, I/O address: wb_data = io_rdata slice (addr-DC_WORDS), sampled in the accept cycle.
- LDR, any other address: wb_data=0, bus_err=1.
- WAIT_DC:
  - dc_rvalid=1 → wb_data=dc_rdata, bus_err=0; go to IDLE.
  - Otherwise the wait counter increments.
  - Counter reaching TIMEOUT → wb_data=0, bus_err=1; go to IDLE. dc_rvalid in that same cycle wins over timeout.
- dc_rvalid outside WAIT_DC is ignored.
- Address compares are unsigned at full ADDR_W. Upper address bits are never truncated.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0. The async assert takes effect immediately.
- Reset mid-WAIT_DC: the pending load is dropped and no write-back is produced. A late dc_rvalid after reset is ignored.
- ALU and I/O paths: accept at cycle T → wb_valid=1 for exactly one cycle at T+1.
- D-cache path:
  - Accept at T.
  - stall=1 from T+1 until the response cycle inclusive.
  - dc_rvalid at T+k (k≥1) → wb_valid at T+k+1.
  - stall=0 at T+k+1, so a new instruction can be accepted at T+k+1.
- Timeout: no dc_rvalid in T+1..T+TIMEOUT → error write-back at T+TIMEOUT+1.
- stall is a function of registered state only; it has no combinational path from valid_in.
- Back-to-back non-stalling instructions give one write-back per cycle.

## Structure
- Package lru_pkg holds:
  - UOP_LDR = 5'd10
  - state enum {IDLE, WAIT_DC}
  - address-region enum {REG_DC, REG_IO, REG_NONE}
- Sub-module lru_addr_decode, combinational: addr → region and I/O index.
- The remaining FSM, counter and output registers live in the top module.

## Test plan
- ADD with alu=0x1234_5678, rd=3 → next cycle: wb_valid=1, wb_rd=3, wb_data=0x1234_5678, bus_err=0, stall=0.
- LDR addr=5, dc_rdata=0xDEAD_BEEF with dc_rvalid 3 cycles after dc_req →
  - dc_req at accept
  - stall high for 3 cycles
  - wb_data=0xDEAD_BEEF one cycle after rvalid
  - new ADD accepted that cycle
- LDR addr=31 with io_rdata[31:0]=0xA5 → wb_data=0xA5 next cycle. LDR addr=32 returns io_rdata[63:32].
- LDR addr=0x1_0000_0021 and LDR addr=40 → wb_data=0, bus_err=1, no dc_req.
- LDR addr=0 with no dc_rvalid → error write-back at accept+16 (TIMEOUT=15). A later dc_rvalid produces nothing.
- rst_n pulsed low during WAIT_DC, then dc_rvalid → no wb_valid, stall=0, outputs zero.
